// File: rtl/multicycle_add_sub.sv
`default_nettype none
// ============================================================================
//  Module      : multicycle_add_sub
//  Description : WIDTH-bit adder/subtractor that reuses one SLICE-bit
//                ripple-carry chain for NSLICE clocks per operation, with a
//                start/ready/done handshake and registered result and flags.
//  Revision    : 1.0 - initial parametrised release
// ============================================================================
module multicycle_add_sub #(
   parameter int WIDTH = 16,
   parameter int SLICE = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic             sub,
   input  logic [WIDTH-1:0] in1,
   input  logic [WIDTH-1:0] in2,
   input  logic             carry_in,
   output logic             ready,
   output logic             done,
   output logic [WIDTH-1:0] out,
   output logic             carry_out,
   output logic             overflow,
   output logic             zero
);

   localparam int NSLICE = WIDTH / SLICE;
   localparam int IDXW   = (NSLICE > 1) ? $clog2(NSLICE) : 1;
   localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NSLICE - 1);

   typedef enum logic [0:0] {
      IDLE = 1'b0,
      RUN  = 1'b1
   } state_t;

   state_t            state_q, state_d;
   logic [IDXW-1:0]   idx_q,   idx_d;
   logic [WIDTH-1:0]  a_q,     a_d;
   logic [WIDTH-1:0]  b_q,     b_d;
   logic              c_q,     c_d;
   logic [WIDTH-1:0]  part_q,  part_d;
   logic [WIDTH-1:0]  out_q,   out_d;
   logic              carry_q, carry_d;
   logic              ovf_q,   ovf_d;
   logic              zero_q,  zero_d;
   logic              done_q,  done_d;

   logic [SLICE-1:0]  a_sl;
   logic [SLICE-1:0]  b_sl;
   logic [SLICE:0]    sl_sum;
   logic [WIDTH-1:0]  full_sum;

   // Shared slice adder: select the current slice, add it, and splice the
   // slice sum into the partial result (a decoded mux keeps indexing static).
   always_comb begin
      a_sl = '0;
      b_sl = '0;
      for (int i = 0; i < NSLICE; i++) begin
         if (idx_q == IDXW'(i)) begin
            a_sl = a_q[i*SLICE +: SLICE];
            b_sl = b_q[i*SLICE +: SLICE];
         end
      end
      sl_sum   = {1'b0, a_sl} + {1'b0, b_sl} + {{SLICE{1'b0}}, c_q};
      full_sum = part_q;
      for (int i = 0; i < NSLICE; i++) begin
         if (idx_q == IDXW'(i)) begin
            full_sum[i*SLICE +: SLICE] = sl_sum[SLICE-1:0];
         end
      end
   end

   // Control FSM and datapath next-state; subtraction is A + ~B + ~borrow,
   // so B and the carry are inverted once at accept time.
   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      a_d     = a_q;
      b_d     = b_q;
      c_d     = c_q;
      part_d  = part_q;
      out_d   = out_q;
      carry_d = carry_q;
      ovf_d   = ovf_q;
      zero_d  = zero_q;
      done_d  = 1'b0;
      case (state_q)
         IDLE: begin
            if (start) begin
               a_d     = in1;
               b_d     = sub ? ~in2 : in2;
               c_d     = carry_in ^ sub;
               idx_d   = '0;
               part_d  = '0;
               state_d = RUN;
            end
         end
         RUN: begin
            part_d = full_sum;
            c_d    = sl_sum[SLICE];
            if (idx_q == LAST_IDX) begin
               out_d   = full_sum;
               carry_d = sl_sum[SLICE];
               ovf_d   = (a_q[WIDTH-1] == b_q[WIDTH-1]) &&
                         (full_sum[WIDTH-1] != a_q[WIDTH-1]);
               zero_d  = (full_sum == '0);
               done_d  = 1'b1;
               idx_d   = '0;
               state_d = IDLE;
            end else begin
               idx_d = idx_q + 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // State and result registers; reset discards any in-flight operation.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         idx_q   <= '0;
         a_q     <= '0;
         b_q     <= '0;
         c_q     <= 1'b0;
         part_q  <= '0;
         out_q   <= '0;
         carry_q <= 1'b0;
         ovf_q   <= 1'b0;
         zero_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         a_q     <= a_d;
         b_q     <= b_d;
         c_q     <= c_d;
         part_q  <= part_d;
         out_q   <= out_d;
         carry_q <= carry_d;
         ovf_q   <= ovf_d;
         zero_q  <= zero_d;
         done_q  <= done_d;
      end
   end

   assign ready     = (state_q == IDLE);
   assign done      = done_q;
   assign out       = out_q;
   assign carry_out = carry_q;
   assign overflow  = ovf_q;
   assign zero      = zero_q;

endmodule
`default_nettype wire

// File: tb/tb_multicycle_add_sub.sv
`default_nettype none
// ============================================================================
//  Module      : tb_multicycle_add_sub
//  Description : Self-checking bench for multicycle_add_sub (SLICE=4 and
//                single-cycle SLICE=16 instances) using an expected-result
//                queue.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_multicycle_add_sub;

   typedef logic [18:0] res_t;   // {out[15:0], carry_out, overflow, zero}

   logic        clk;
   logic        reset;
   logic        start4, start16;
   logic        sub;
   logic [15:0] in1, in2;
   logic        carry_in;
   logic        ready4, done4, co4, ov4, z4;
   logic [15:0] out4;
   logic        ready16, done16, co16, ov16, z16;
   logic [15:0] out16;

   int   tests = 0;
   int   fails = 0;
   res_t exp_q[$];

   multicycle_add_sub #(.WIDTH(16), .SLICE(4)) u_dut4 (
      .clk(clk), .reset(reset), .start(start4), .sub(sub), .in1(in1), .in2(in2),
      .carry_in(carry_in), .ready(ready4), .done(done4), .out(out4),
      .carry_out(co4), .overflow(ov4), .zero(z4)
   );

   multicycle_add_sub #(.WIDTH(16), .SLICE(16)) u_dut16 (
      .clk(clk), .reset(reset), .start(start16), .sub(sub), .in1(in1), .in2(in2),
      .carry_in(carry_in), .ready(ready16), .done(done16), .out(out16),
      .carry_out(co16), .overflow(ov16), .zero(z16)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference arithmetic, written as plain add / subtract-with-borrow.
   function automatic res_t model(input logic s, input logic [15:0] a,
                                  input logic [15:0] b, input logic c);
      logic [16:0] t;
      logic [15:0] o;
      logic        co, ov;
      if (!s) begin
         t  = {1'b0, a} + {1'b0, b} + {16'b0, c};
         o  = t[15:0];
         co = t[16];
         ov = (a[15] == b[15]) && (o[15] != a[15]);
      end else begin
         t  = {1'b0, a} - {1'b0, b} - {16'b0, c};
         o  = t[15:0];
         co = ~t[16];
         ov = (a[15] != b[15]) && (o[15] != a[15]);
      end
      return {o, co, ov, (o == 16'h0000)};
   endfunction

   // Drive one request; returns just after the accepting edge.
   task automatic issue(input bit wide, input logic s, input logic [15:0] a,
                        input logic [15:0] b, input logic c);
      sub = s; in1 = a; in2 = b; carry_in = c;
      if (wide) start16 = 1'b1; else start4 = 1'b1;
      @(posedge clk); #1;
      start4 = 1'b0; start16 = 1'b0;
   endtask

   // Wait (bounded) for done; lat counts edges since the accept edge, -1 on timeout.
   task automatic collect(input bit wide, input int lat0, output int lat, output res_t r);
      bit found;
      found = 1'b0;
      lat   = lat0;
      r     = '0;
      while (!found && lat < 40) begin
         @(posedge clk); #1;
         lat++;
         if ((wide ? done16 : done4) === 1'b1) begin
            found = 1'b1;
            r = wide ? {out16, co16, ov16, z16} : {out4, co4, ov4, z4};
         end
      end
      if (!found) lat = -1;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      tests++;
      if ({ready4, done4, out4, co4, ov4, z4} !== {1'b1, 1'b0, 16'h0, 3'b000}) begin
         fails++;
         $display("FAIL reset_state4: got rdy=%b done=%b out=%h f=%b%b%b expected 1 0 0000 000",
                  ready4, done4, out4, co4, ov4, z4);
      end
      tests++;
      if ({ready16, done16, out16, co16, ov16, z16} !== {1'b1, 1'b0, 16'h0, 3'b000}) begin
         fails++;
         $display("FAIL reset_state16: got rdy=%b done=%b out=%h f=%b%b%b expected 1 0 0000 000",
                  ready16, done16, out16, co16, ov16, z16);
      end
      reset = 1'b0;
   endtask

   task automatic test_add_basic();
      int lat; res_t got, exp;
      issue(0, 1'b0, 16'h1234, 16'h4321, 1'b0);
      exp_q.push_back({16'h5555, 3'b000});
      collect(0, 0, lat, got);
      exp = exp_q.pop_front();
      tests++;
      if (lat !== 4) begin fails++; $display("FAIL add_basic_latency: got %0d expected 4", lat); end
      tests++;
      if (got !== exp) begin fails++; $display("FAIL add_basic: got %h expected %h", got, exp); end
   endtask

   task automatic test_wrap();
      int lat; res_t got, exp;
      logic [15:0] a_tab [2] = '{16'hFFFF, 16'h7FFF};
      res_t        e_tab [2] = '{{16'h0000, 3'b101}, {16'h8000, 3'b010}};
      for (int i = 0; i < 2; i++) begin
         issue(0, 1'b0, a_tab[i], 16'h0001, 1'b0);
         exp_q.push_back(e_tab[i]);
         collect(0, 0, lat, got);
         exp = exp_q.pop_front();
         tests++;
         if (got !== exp) begin fails++; $display("FAIL wrap_%0d: got %h expected %h", i, got, exp); end
      end
   endtask

   task automatic test_sub();
      int lat; res_t got, exp;
      logic [15:0] a_tab [2] = '{16'h0005, 16'h8000};
      logic [15:0] b_tab [2] = '{16'h0007, 16'h0001};
      res_t        e_tab [2] = '{{16'hFFFE, 3'b000}, {16'h7FFF, 3'b110}};
      for (int i = 0; i < 2; i++) begin
         issue(0, 1'b1, a_tab[i], b_tab[i], 1'b0);
         exp_q.push_back(e_tab[i]);
         collect(0, 0, lat, got);
         exp = exp_q.pop_front();
         tests++;
         if (got !== exp) begin fails++; $display("FAIL sub_%0d: got %h expected %h", i, got, exp); end
      end
   endtask

   task automatic test_carry_chain();
      int lat; res_t got, exp;
      issue(0, 1'b0, 16'h00FF, 16'h0001, 1'b1);
      exp_q.push_back({16'h0101, 3'b000});
      collect(0, 0, lat, got);
      exp = exp_q.pop_front();
      tests++;
      if (got !== exp) begin fails++; $display("FAIL carry_chain: got %h expected %h", got, exp); end
   endtask

   task automatic test_busy();
      int lat; res_t got, exp;
      issue(0, 1'b0, 16'h2468, 16'h1357, 1'b0);
      exp_q.push_back({16'h37BF, 3'b000});
      @(posedge clk); #1;
      @(posedge clk); #1;
      // Stray start plus operand changes while busy.
      start4 = 1'b1; sub = 1'b1; in1 = 16'hFFFF; in2 = 16'hFFFF; carry_in = 1'b1;
      @(posedge clk); #1;
      start4 = 1'b0;
      collect(0, 3, lat, got);
      exp = exp_q.pop_front();
      tests++;
      if (lat !== 4) begin fails++; $display("FAIL busy_latency: got %0d expected 4", lat); end
      tests++;
      if (got !== exp) begin fails++; $display("FAIL busy_result: got %h expected %h", got, exp); end
      @(posedge clk); #1;
      tests++;
      if ({done4, ready4} !== 2'b01) begin
         fails++; $display("FAIL busy_no_restart: got done=%b ready=%b expected 0 1", done4, ready4);
      end
   endtask

   task automatic test_back_to_back();
      int lat; res_t got, exp;
      issue(0, 1'b0, 16'h1000, 16'h2000, 1'b0);
      exp_q.push_back({16'h3000, 3'b000});
      collect(0, 0, lat, got);
      exp = exp_q.pop_front();
      tests++;
      if (got !== exp) begin fails++; $display("FAIL b2b_first: got %h expected %h", got, exp); end
      tests++;
      if (ready4 !== 1'b1) begin fails++; $display("FAIL b2b_ready_in_done: got %b expected 1", ready4); end
      issue(0, 1'b0, 16'h0F0F, 16'h1010, 1'b0);
      exp_q.push_back({16'h1F1F, 3'b000});
      collect(0, 0, lat, got);
      exp = exp_q.pop_front();
      tests++;
      if (lat !== 4) begin fails++; $display("FAIL b2b_latency: got %0d expected 4", lat); end
      tests++;
      if (got !== exp) begin fails++; $display("FAIL b2b_second: got %h expected %h", got, exp); end
   endtask

   task automatic test_reset_mid_run();
      int late;
      issue(0, 1'b0, 16'h1111, 16'h2222, 1'b0);
      @(posedge clk); #1;
      reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
      tests++;
      if ({ready4, done4, out4, z4} !== {1'b1, 1'b0, 16'h0000, 1'b0}) begin
         fails++;
         $display("FAIL reset_mid_run: got rdy=%b done=%b out=%h zero=%b expected 1 0 0000 0",
                  ready4, done4, out4, z4);
      end
      late = 0;
      repeat (8) begin
         @(posedge clk); #1;
         if (done4 === 1'b1) late++;
      end
      tests++;
      if (late !== 0) begin fails++; $display("FAIL reset_no_late_done: got %0d done pulses expected 0", late); end
   endtask

   task automatic test_random();
      int lat; res_t got, exp;
      logic s, c; logic [15:0] a, b;
      for (int i = 0; i < 8; i++) begin
         bit wide;
         wide = (i >= 5);
         a = 16'($urandom); b = 16'($urandom);
         s = 1'($urandom); c = 1'($urandom);
         exp_q.push_back(model(s, a, b, c));
         issue(wide, s, a, b, c);
         collect(wide, 0, lat, got);
         exp = exp_q.pop_front();
         tests++;
         if (got !== exp) begin
            fails++;
            $display("FAIL random_%0d (s=%b a=%h b=%h c=%b): got %h expected %h", i, s, a, b, c, got, exp);
         end
      end
   endtask

   task automatic test_single_cycle();
      int lat; res_t got, exp;
      issue(1, 1'b0, 16'hABCD, 16'h1111, 1'b0);
      exp_q.push_back({16'hBCDE, 3'b000});
      collect(1, 0, lat, got);
      exp = exp_q.pop_front();
      tests++;
      if (lat !== 1) begin fails++; $display("FAIL single_latency: got %0d expected 1", lat); end
      tests++;
      if (got !== exp) begin fails++; $display("FAIL single_result: got %h expected %h", got, exp); end
   endtask

   initial begin
      reset = 1'b0; start4 = 1'b0; start16 = 1'b0;
      sub = 1'b0; in1 = '0; in2 = '0; carry_in = 1'b0;
      test_reset();
      test_add_basic();
      test_wrap();
      test_sub();
      test_carry_chain();
      test_busy();
      test_back_to_back();
      test_reset_mid_run();
      test_random();
      test_single_cycle();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

endmodule
`default_nettype wire
